// File: rtl/fmc_pkg.sv
// Shared FMC definitions: controller state encoding and default bus timing,
// used by both the initiator and the responder side of the FMC link.
package fmc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } fmc_state_e;

  localparam int AddrCycles = 2;
  localparam int DataCycles = 4;
  localparam int HoldCycles = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fmc_initiator.sv
// FMC multiplexed address/data bus initiator: turns one request into an
// ADDR/DATA/HOLD strobe sequence and returns a single-cycle completion.
module fmc_initiator #(
  parameter int Width      = 16,
  parameter int AddrCycles = fmc_pkg::AddrCycles,
  parameter int DataCycles = fmc_pkg::DataCycles,
  parameter int HoldCycles = fmc_pkg::HoldCycles
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [Width-1:0] req_addr,
  input  logic [Width-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [Width-1:0] rsp_rdata,
  output logic             fmc_ne_n,
  output logic             fmc_noe_n,
  output logic             fmc_nwe_n,
  output logic             fmc_nadv_n,
  output logic [Width-1:0] ad_out,
  input  logic [Width-1:0] ad_in,
  output logic             ad_tristate
);

  localparam int CntW = $clog2(fmc_pkg::max3(AddrCycles, DataCycles, HoldCycles) + 1);

  if (AddrCycles < 1 || DataCycles < 1 || HoldCycles < 1) begin : g_bad_timing
    $error("fmc_initiator: every phase must last at least one cycle");
  end

  fmc_pkg::fmc_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [Width-1:0] addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [Width-1:0] rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             ne_n_q, ne_n_d;
  logic             noe_n_q, noe_n_d;
  logic             nwe_n_q, nwe_n_d;
  logic             nadv_n_q, nadv_n_d;
  logic [Width-1:0] ad_out_q, ad_out_d;
  logic             tri_q, tri_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      fmc_pkg::IDLE: begin
        if (req_valid && ready_q) begin
          state_d = fmc_pkg::ADDR;
          cnt_d   = CntW'(AddrCycles - 1);
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      fmc_pkg::ADDR: begin
        if (cnt_q == '0) begin
          state_d = fmc_pkg::DATA;
          cnt_d   = CntW'(DataCycles - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      fmc_pkg::DATA: begin
        if (cnt_q == '0) begin
          state_d = fmc_pkg::HOLD;
          cnt_d   = CntW'(HoldCycles - 1);
          if (!write_q) begin
            rdata_d = ad_in;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      fmc_pkg::HOLD: begin
        if (cnt_q == '0) begin
          state_d     = fmc_pkg::IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase

    // Pad and strobe values are decoded from the next state so they come
    // straight out of flops; the bus is released on the same edge that
    // asserts output-enable.
    ready_d  = (state_d == fmc_pkg::IDLE);
    ne_n_d   = 1'b1;
    noe_n_d  = 1'b1;
    nwe_n_d  = 1'b1;
    nadv_n_d = 1'b1;
    tri_d    = 1'b1;
    ad_out_d = ad_out_q;

    case (state_d)
      fmc_pkg::IDLE: begin
      end
      fmc_pkg::ADDR: begin
        ne_n_d   = 1'b0;
        nadv_n_d = 1'b0;
        tri_d    = 1'b0;
        ad_out_d = addr_d;
      end
      fmc_pkg::DATA: begin
        ne_n_d = 1'b0;
        if (write_d) begin
          nwe_n_d  = 1'b0;
          tri_d    = 1'b0;
          ad_out_d = wdata_d;
        end else begin
          noe_n_d = 1'b0;
        end
      end
      fmc_pkg::HOLD: begin
        ne_n_d = 1'b0;
        if (write_d) begin
          tri_d    = 1'b0;
          ad_out_d = wdata_d;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= fmc_pkg::IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      ne_n_q      <= 1'b1;
      noe_n_q     <= 1'b1;
      nwe_n_q     <= 1'b1;
      nadv_n_q    <= 1'b1;
      ad_out_q    <= '0;
      tri_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      ne_n_q      <= ne_n_d;
      noe_n_q     <= noe_n_d;
      nwe_n_q     <= nwe_n_d;
      nadv_n_q    <= nadv_n_d;
      ad_out_q    <= ad_out_d;
      tri_q       <= tri_d;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign fmc_ne_n    = ne_n_q;
  assign fmc_noe_n   = noe_n_q;
  assign fmc_nwe_n   = nwe_n_q;
  assign fmc_nadv_n  = nadv_n_q;
  assign ad_out      = ad_out_q;
  assign ad_tristate = tri_q;

endmodule

// File: tb/tb_fmc_initiator.sv
// Directed checks of the default-timing initiator plus a randomized
// single-cycle-phase instance checking handshake and bus-turnaround rules.
module tb_fmc_initiator;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_write;
  logic [15:0] req_addr, req_wdata, ad_in;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_rdata, ad_out;
  logic        fmc_ne_n, fmc_noe_n, fmc_nwe_n, fmc_nadv_n, ad_tristate;

  logic        r_req_valid, r_req_write;
  logic [15:0] r_req_addr, r_req_wdata, r_ad_in;
  logic        r_req_ready, r_rsp_valid;
  logic [15:0] r_rsp_rdata, r_ad_out;
  logic        r_ne_n, r_noe_n, r_nwe_n, r_nadv_n, r_tristate;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_rdata;

  always #5 clk = ~clk;

  fmc_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .fmc_ne_n(fmc_ne_n), .fmc_noe_n(fmc_noe_n), .fmc_nwe_n(fmc_nwe_n),
    .fmc_nadv_n(fmc_nadv_n), .ad_out(ad_out), .ad_in(ad_in),
    .ad_tristate(ad_tristate)
  );

  fmc_initiator #(.Width(16), .AddrCycles(1), .DataCycles(1), .HoldCycles(1)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r_req_valid), .req_ready(r_req_ready), .req_write(r_req_write),
    .req_addr(r_req_addr), .req_wdata(r_req_wdata),
    .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata),
    .fmc_ne_n(r_ne_n), .fmc_noe_n(r_noe_n), .fmc_nwe_n(r_nwe_n),
    .fmc_nadv_n(r_nadv_n), .ad_out(r_ad_out), .ad_in(r_ad_in),
    .ad_tristate(r_tristate)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] ctrlVec();
    return {fmc_ne_n, fmc_noe_n, fmc_nwe_n, fmc_nadv_n, ad_tristate, req_ready, rsp_valid};
  endfunction

  // {ne_n, noe_n, nwe_n, nadv_n, tristate, ready, rsp_valid} for cycle k of a transaction
  function automatic logic [6:0] expCtrl(input int k, input bit wr);
    if (k <= 2)      return 7'b0110000;
    else if (k <= 6) return wr ? 7'b0101000 : 7'b0011100;
    else if (k == 7) return wr ? 7'b0111000 : 7'b0111100;
    else             return 7'b1111111;
  endfunction

  // Present one request at a negedge, let it be accepted, then drive the next
  // request (chain=1) or junk (chain=0) and check cycles 1..8 of this one.
  task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] rdin, input bit chain, input bit nwr,
                               input logic [15:0] naddr, input logic [15:0] nwdata);
    string tag;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = chain;
    req_write = nwr;
    req_addr  = naddr;
    req_wdata = nwdata;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ad_in = (k >= 3 && k <= 6) ? rdin : ~rdin;
      tag = $sformatf("%s@%04h c%0d", wr ? "wr" : "rd", addr, k);
      checkOutput({tag, " ctrl"}, 32'(ctrlVec()), 32'(expCtrl(k, wr)));
      if (k <= 2)
        checkOutput({tag, " ad_out"}, 32'(ad_out), 32'(addr));
      else if (wr && k <= 7)
        checkOutput({tag, " ad_out"}, 32'(ad_out), 32'(wdata));
      if (k == 8) begin
        if (!wr) exp_rdata = rdin;
        checkOutput({tag, " rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("idle ctrl", 32'(ctrlVec()), 32'(7'b1111110));
      checkOutput("idle rdata", 32'(rsp_rdata), 32'(exp_rdata));
    end
  endtask

  initial begin
    int acc, rsp, orphan, laterr, viol, cyc, acc_cyc;
    bit pend;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; ad_in = '0;
    r_req_valid = 1'b0; r_req_write = 1'b0; r_req_addr = '0; r_req_wdata = '0; r_ad_in = '0;
    exp_rdata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ctrl", 32'(ctrlVec()), 32'(7'b1111110));
    checkOutput("reset ad_out", 32'(ad_out), 32'h0);
    checkOutput("reset rdata", 32'(rsp_rdata), 32'h0);
    rst_n = 1'b1;
    idleCycles(2);

    applyStimulus(1'b1, 16'h1234, 16'hBEEF, 16'h0F0F, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
    idleCycles(2);
    applyStimulus(1'b0, 16'h0042, 16'h5555, 16'hCAFE, 1'b0, 1'b1, 16'hAAAA, 16'h9999);
    idleCycles(1);

    applyStimulus(1'b1, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, 16'h0ABC, 16'h3333);
    applyStimulus(1'b0, 16'h0ABC, 16'h3333, 16'h5A5A, 1'b1, 1'b1, 16'h0777, 16'h8888);
    applyStimulus(1'b1, 16'h0777, 16'h8888, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idleCycles(2);

    // Reset arrives at the edge ending the 2nd DATA cycle of a write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h2468; req_wdata = 16'h1357;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre-abort ctrl", 32'(ctrlVec()), 32'(7'b0101000));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 16'h0000;
    checkOutput("abort ctrl", 32'(ctrlVec()), 32'(7'b1111110));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("post-abort rsp_valid", 32'(rsp_valid), 32'h0);
    end

    acc = 0; rsp = 0; orphan = 0; laterr = 0; viol = 0; cyc = 0; acc_cyc = 0; pend = 1'b0;
    while (acc < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!r_noe_n && !r_tristate) viol++;
      if (r_rsp_valid) begin
        rsp++;
        if (!pend) orphan++;
        else if (cyc != acc_cyc + 4) laterr++;
        pend = 1'b0;
      end
      r_req_valid = ($urandom_range(0, 3) != 0);
      r_req_write = 1'($urandom_range(0, 1));
      r_req_addr  = 16'($urandom);
      r_req_wdata = 16'($urandom);
      r_ad_in     = 16'($urandom);
      if (r_req_valid && r_req_ready) begin
        if (pend) orphan++;
        acc++;
        pend = 1'b1;
        acc_cyc = cyc;
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cyc++;
      r_req_valid = 1'b0;
      if (!r_noe_n && !r_tristate) viol++;
      if (r_rsp_valid) begin
        rsp++;
        if (!pend) orphan++;
        else if (cyc != acc_cyc + 4) laterr++;
        pend = 1'b0;
      end
    end
    checkOutput("rnd accepts", 32'(acc), 32'd1000);
    checkOutput("rnd responses", 32'(rsp), 32'(acc));
    checkOutput("rnd orphan", 32'(orphan), 32'd0);
    checkOutput("rnd latency", 32'(laterr), 32'd0);
    checkOutput("rnd drive-while-oe", 32'(viol), 32'd0);
    checkOutput("rnd pending", 32'(pend), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmc_initiator.md
FMC_INITIATOR -- requirements
Module: fmc_initiator

Interface
REQ-001 Width, 16, width of the multiplexed address/data bus and of req_addr/req_wdata/rsp_rdata, in bits.
REQ-002 AddrCycles, 2, number of clk cycles in the address phase; must be >= 1.
REQ-003 DataCycles, 4, number of clk cycles in the data phase; must be >= 1.
REQ-004 HoldCycles, 1, number of clk cycles in the hold phase; must be >= 1.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  1  a transaction request is presented.
REQ-008 req_ready  output  1  the block accepts a request this cycle.
REQ-009 req_write  input  1  1 selects write, 0 selects read.
REQ-010 req_addr  input  Width  transaction address.
REQ-011 req_wdata  input  Width  write data.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  Width  read data; valid while rsp_valid is high after a read.
REQ-014 fmc_ne_n, fmc_noe_n, fmc_nwe_n, fmc_nadv_n  output  1 each  active-low chip-enable, output-enable, write-enable and address-valid strobes.
REQ-015 ad_out  output  Width  value driven onto the pads.
REQ-016 ad_in  input  Width  value sampled from the pads.
REQ-017 ad_tristate  output  1  1 releases the pads (high-Z), 0 drives ad_out; connects directly to the T input of the FMC data-bus I/O buffer.

Function
REQ-018 All outputs shall be registered, with no combinational path from any input to any output.
REQ-019 The FSM shall have the states IDLE, ADDR, DATA and HOLD; req_ready shall be 1 only in IDLE.
REQ-020 A request is accepted on req_valid && req_ready; req_write, req_addr and req_wdata shall be captured at that edge, and later input changes shall be ignored until the transaction completes.
REQ-021 ADDR shall last AddrCycles cycles with the following outputs:
- fmc_ne_n=0, fmc_nadv_n=0;
- ad_out=captured address, ad_tristate=0;
- fmc_noe_n=fmc_nwe_n=1.
REQ-022 DATA shall last DataCycles cycles with fmc_nadv_n=1 and fmc_ne_n=0, plus:
- write: fmc_nwe_n=0, ad_out=captured wdata, ad_tristate=0;
- read: fmc_noe_n=0, ad_tristate=1.
REQ-023 On a read, ad_in shall be registered into rsp_rdata on the clock edge that ends the last DATA cycle.
REQ-024 HOLD shall last HoldCycles cycles with the following outputs:
- fmc_ne_n=0, fmc_noe_n=fmc_nwe_n=fmc_nadv_n=1;
- write: ad_out=wdata, ad_tristate=0;
- read: ad_tristate=1.
REQ-025 On HOLD exit the FSM shall enter IDLE, with fmc_ne_n=1, ad_tristate=1, req_ready=1 and rsp_valid=1 for exactly one cycle, for both reads and writes.
REQ-026 Latency: with acceptance at edge 0, rsp_valid shall be high in cycle AddrCycles+DataCycles+HoldCycles+1, and a new request may be accepted in that same cycle.
REQ-027 rsp_rdata shall hold its last read value across writes and idle periods.
REQ-028 The block shall never drive the pads (ad_tristate=0) while fmc_noe_n=0; the read turnaround is guaranteed by ADDR->DATA releasing the bus on the same edge that asserts fmc_noe_n.
REQ-029 The phase counter width shall be $clog2(max(AddrCycles,DataCycles,HoldCycles)+1).
REQ-030 Any cycle parameter < 1 shall be an elaboration error.

Reset
REQ-031 While rst_n=0 at a clk edge:
- state shall be IDLE;
- req_ready=1, rsp_valid=0, rsp_rdata=0, ad_out=0;
- ad_tristate=1;
- all fmc_*_n strobes=1.
REQ-032 Reset asserted mid-transaction shall abort it with no rsp_valid, and all strobes shall deassert on that edge.

Structure
REQ-033 Package fmc_pkg shall hold the state enum and the default timing constants (AddrCycles, DataCycles, HoldCycles) shared with the FMC responder side.
REQ-034 The design shall be a single FSM plus one down-counter; no sub-module is required.

Verification
REQ-035 Defaults; write addr=0x1234 data=0xBEEF -> the following sequence:
- 2 cycles nadv_n=0 with ad_out=0x1234;
- 4 cycles nwe_n=0 with ad_out=0xBEEF;
- 1 hold cycle;
- rsp_valid in cycle 8.
REQ-036 Read addr=0x0042 with ad_in=0xCAFE held during DATA -> noe_n=0 for 4 cycles, ad_tristate=1 throughout DATA/HOLD, rsp_rdata=0xCAFE with rsp_valid in cycle 8.
REQ-037 req_valid held high with back-to-back write then read -> second accept in the rsp_valid cycle of the first, ne_n high for exactly that one cycle, and a write after a read leaves rsp_rdata unchanged.
REQ-038 rst_n low during the 2nd DATA cycle of a write -> next cycle all strobes=1, ad_tristate=1, req_ready=1, no rsp_valid.
REQ-039 Random traffic, 1000 transactions, AddrCycles=1, DataCycles=1, HoldCycles=1 -> assertion that ad_tristate=1 whenever noe_n=0 never fails, and every accept yields exactly one rsp_valid.
